cache_tag_ctrl: RTL and testbench

- Direct-mapped cache lookup controller that owns and sequences the single-port, synchronous-read tag RAM (default 8 entries x 14 bits, entry = {valid, tag[12:0]}).
- Accepts CPU requests, performs tag lookup and compare, and issues line-refill handshakes to the memory side on read miss.
- Writes the new tag on refill and performs power-up and flush invalidation sweeps.
- Sits between the CPU interface and the tag RAM / memory refill path.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_tag_cmp.sv | 14 +
 rtl/cache_tag_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizes for the direct-mapped cache tag controller.
// Tag entries are {valid, tag}; the valid flag sits above the tag bits.
package cache_pkg;

  localparam int TAG_W     = 13;
  localparam int INDEX_W   = 3;
  localparam int OFFSET_W  = 2;
  localparam int ADDR_W    = TAG_W + INDEX_W + OFFSET_W;
  localparam int VALID_BIT = TAG_W;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_UPDATE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/cache_tag_cmp.sv
// Valid + tag comparator for one tag-RAM entry.
// Kept separate so set-associative variants can instance one per way.
module cache_tag_cmp #(
  parameter int TAG_W = 13
) (
  input  logic [TAG_W:0]   entry,
  input  logic [TAG_W-1:0] tag,
  output logic             hit
);

  // hit needs a valid entry whose stored tag matches
  assign hit = entry[TAG_W] && (entry[TAG_W-1:0] == tag);

endmodule

// File: rtl/cache_tag_ctrl.sv
// Direct-mapped tag lookup controller: lookup, refill handshake,
// tag update and invalidation sweeps of an external tag RAM.
module cache_tag_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_W  = cache_pkg::INDEX_W,
  parameter int TAG_W    = cache_pkg::TAG_W,
  parameter int OFFSET_W = cache_pkg::OFFSET_W,
  parameter int ADDR_W   = TAG_W + INDEX_W + OFFSET_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_we,
  output logic              cpu_resp_valid,
  output logic              cpu_resp_hit,
  input  logic              flush,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [INDEX_W-1:0] tag_addr,
  output logic [TAG_W:0]    tag_din,
  output logic              tag_we,
  input  logic [TAG_W:0]    tag_dout
);

  localparam logic [INDEX_W-1:0] LAST = '1;

  state_t state, state_n;

  logic [INDEX_W-1:0] sweep, sweep_n;
  logic [INDEX_W-1:0] idx, idx_n;
  logic [TAG_W-1:0]   tag_q, tag_n;
  logic               we_q, we_n;

  logic               resp_valid_n;
  logic               resp_hit_n;
  logic               busy_n;
  logic               mem_req_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic [TAG_W:0]     tag_din_n;
  logic               tag_we_n;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               unused_off;

  assign req_idx = cpu_req_addr[OFFSET_W +: INDEX_W];
  assign req_tag = cpu_req_addr[ADDR_W-1 -: TAG_W];
  assign unused_off = ^cpu_req_addr[OFFSET_W-1:0];

  cache_tag_cmp #(
    .TAG_W(TAG_W)
  ) u_cmp (
    .entry(tag_dout),
    .tag  (tag_q),
    .hit  (hit)
  );

  assign cpu_req_ready = (state == ST_IDLE) && !flush;

  // RAM address: sweep pointer, live request index, or held index
  always_comb begin
    tag_addr = idx;
    unique case (1'b1)
      state == ST_INIT: tag_addr = sweep;
      state == ST_IDLE: tag_addr = req_idx;
      default:          tag_addr = idx;
    endcase
  end

  // next state and next values of the registered outputs
  always_comb begin
    state_n      = state;
    sweep_n      = sweep;
    idx_n        = idx;
    tag_n        = tag_q;
    we_n         = we_q;
    resp_valid_n = 1'b0;
    resp_hit_n   = 1'b0;
    mem_req_n    = 1'b0;
    mem_addr_n   = mem_addr;
    tag_din_n    = '0;
    tag_we_n     = 1'b0;
    unique case (state)
      ST_INIT: begin
        tag_we_n = 1'b1;
        if (tag_we) begin
          sweep_n = sweep + 1'b1;
          if (sweep == LAST) begin
            state_n  = ST_IDLE;
            tag_we_n = 1'b0;
          end
        end
      end
      ST_IDLE: begin
        if (flush) begin
          state_n  = ST_INIT;
          tag_we_n = 1'b1;
        end else if (cpu_req_valid) begin
          idx_n   = req_idx;
          tag_n   = req_tag;
          we_n    = cpu_req_we;
          state_n = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
          resp_hit_n   = 1'b1;
        end else if (we_q) begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
        end else begin
          state_n    = ST_MISS;
          mem_req_n  = 1'b1;
          mem_addr_n = {tag_q, idx, {OFFSET_W{1'b0}}};
        end
      end
      ST_MISS: begin
        if (mem_ack) begin
          state_n   = ST_UPDATE;
          tag_we_n  = 1'b1;
          tag_din_n = {1'b1, tag_q};
        end else begin
          mem_req_n = 1'b1;
        end
      end
      ST_UPDATE: begin
        state_n      = ST_RESP;
        resp_valid_n = 1'b1;
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // state, request context and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_INIT;
      sweep          <= '0;
      idx            <= '0;
      tag_q          <= '0;
      we_q           <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_hit   <= 1'b0;
      busy           <= 1'b1;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      tag_din        <= '0;
      tag_we         <= 1'b0;
    end else begin
      state          <= state_n;
      sweep          <= sweep_n;
      idx            <= idx_n;
      tag_q          <= tag_n;
      we_q           <= we_n;
      cpu_resp_valid <= resp_valid_n;
      cpu_resp_hit   <= resp_hit_n;
      busy           <= busy_n;
      mem_req        <= mem_req_n;
      mem_addr       <= mem_addr_n;
      tag_din        <= tag_din_n;
      tag_we         <= tag_we_n;
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl with a behavioural tag RAM.
// Responses are matched against queued hit/cycle expectations.
module tb_cache_tag_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic [17:0] cpu_req_addr = '0;
  logic        cpu_req_we = 1'b0;
  logic        cpu_resp_valid;
  logic        cpu_resp_hit;
  logic        flush = 1'b0;
  logic        busy;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [2:0]  tag_addr;
  logic [13:0] tag_din;
  logic        tag_we;
  logic [13:0] tag_dout = '0;

  // stale power-up contents: valid entries with tag 0
  logic [13:0] ram [8] = '{default: 14'h2000};

  typedef struct {
    logic hit;
    int   at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  cache_tag_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_we    (cpu_req_we),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_hit  (cpu_resp_hit),
    .flush         (flush),
    .busy          (busy),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .tag_addr      (tag_addr),
    .tag_din       (tag_din),
    .tag_we        (tag_we),
    .tag_dout      (tag_dout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (tag_we) ram[tag_addr] <= tag_din;
    tag_dout <= ram[tag_addr];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && cpu_resp_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_resp", {31'd0, cpu_resp_valid}, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("resp_hit", {31'd0, cpu_resp_hit}, {31'd0, mon_e.hit});
        check("resp_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic sweep_check();
    int n = 0;
    for (int k = 0; k < 20; k++) begin
      if (tag_we) begin
        check("sweep_addr", {29'd0, tag_addr}, n);
        check("sweep_din", {18'd0, tag_din}, 0);
        n++;
      end else if (n > 0) begin
        break;
      end
      tick();
    end
    check("sweep_len", n, 8);
    check("ready_after_sweep", {31'd0, cpu_req_ready}, 1);
    check("busy_after_sweep", {31'd0, busy}, 0);
  endtask

  // kind: 0 hit, 1 write miss, 2 read miss, 3 read miss cut by reset
  task automatic req(input logic [17:0] a,
                     input logic w,
                     input int kind);
    int   c;
    logic seen;
    exp_t e;
    cpu_req_addr  = a;
    cpu_req_we    = w;
    cpu_req_valid = 1'b1;
    #1;
    check("ready", {31'd0, cpu_req_ready}, 1);
    c = cyc;
    tick();
    cpu_req_valid = 1'b0;
    if (kind < 2) begin
      e.hit = (kind == 0);
      e.at  = c + 2;
      sbq.push_back(e);
      for (int i = 0; i < 4; i++) begin
        check("no_mem_req", {31'd0, mem_req}, 0);
        check("no_tag_we", {31'd0, tag_we}, 0);
        tick();
      end
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        tick();
        seen = mem_req;
      end
      check("mem_req_seen", {31'd0, seen}, 1);
      if (kind == 3) begin
        reset_n = 1'b0;
        #1;
        check("mem_req_reset", {31'd0, mem_req}, 0);
        check("resp_reset", {31'd0, cpu_resp_valid}, 0);
        return;
      end
      for (int i = 0; i < 3; i++) begin
        check("mem_addr", {14'd0, mem_addr},
              {14'd0, a[17:2], 2'b00});
        check("mem_req_hold", {31'd0, mem_req}, 1);
        tick();
      end
      mem_ack = 1'b1;
      c = cyc;
      e.hit = 1'b0;
      e.at  = c + 2;
      sbq.push_back(e);
      tick();
      mem_ack = 1'b0;
      check("upd_we", {31'd0, tag_we}, 1);
      check("upd_addr", {29'd0, tag_addr}, {29'd0, a[4:2]});
      check("upd_din", {18'd0, tag_din}, {18'd0, 1'b1, a[17:5]});
      check("upd_mem_req", {31'd0, mem_req}, 0);
      tick();
      tick();
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    tick();
    check("rst_ready", {31'd0, cpu_req_ready}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_tag_we", {31'd0, tag_we}, 0);
    check("rst_resp", {31'd0, cpu_resp_valid}, 0);
    check("rst_hit", {31'd0, cpu_resp_hit}, 0);
    check("rst_din", {18'd0, tag_din}, 0);
    check("rst_mem_addr", {14'd0, mem_addr}, 0);
    reset_n = 1'b1;
    sweep_check();

    req(18'h00004, 1'b0, 2);
    req(18'h00004, 1'b0, 0);
    req(18'h00005, 1'b0, 0);
    req(18'h3FFFC, 1'b1, 1);

    flush         = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 18'h00004;
    cpu_req_we    = 1'b0;
    #1;
    check("flush_ready", {31'd0, cpu_req_ready}, 0);
    tick();
    flush         = 1'b0;
    cpu_req_valid = 1'b0;
    sweep_check();
    req(18'h00004, 1'b0, 2);

    req(18'h00108, 1'b0, 3);
    tick();
    tick();
    reset_n = 1'b1;
    sweep_check();
    req(18'h00108, 1'b0, 2);
    req(18'h00108, 1'b0, 0);

    tick();
    tick();
    tick();
    check("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
